// File: rtl/n1_core.sv
// n1_core: accumulator micro-sequencer with byte-serial program load.
// Two-cycle fetch/execute over a 16-bit program RAM and a data RAM.
module n1_core #(
  parameter int DATA_W  = 8,
  parameter int PROG_AW = 4,
  parameter int DATA_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              start,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              halted,
  output logic [PROG_AW-1:0] pc_dbg
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  localparam int PDEPTH = 2 ** PROG_AW;
  localparam int DDEPTH = 2 ** DATA_AW;
  localparam logic [PROG_AW-1:0] P_ONE = 1;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [15:0]        pram [PDEPTH];
  logic [DATA_W-1:0]  dram [DDEPTH];

  state_t             state;
  logic [PROG_AW-1:0] pc;
  logic [DATA_W-1:0]  acc;
  logic               c_flag;
  logic [15:0]        inst;
  logic [PROG_AW-1:0] ptr;
  logic               phase_lo;
  logic [7:0]         hi_byte;

  logic [3:0]         op;
  logic [DATA_AW-1:0] a;
  logic [DATA_W-1:0]  imm;
  logic [PROG_AW-1:0] tgt;
  logic [DATA_W-1:0]  dval;
  logic [DATA_W:0]    sum;
  logic [DATA_W:0]    diff;
  logic               z_flag;
  logic               idle;
  logic               load_fire;
  logic               exec_st;
  logic               unused_bits;

  assign op   = inst[15:12];
  assign a    = inst[DATA_AW-1:0];
  assign imm  = inst[DATA_W-1:0];
  assign tgt  = inst[PROG_AW-1:0];
  assign dval = dram[a];
  assign sum  = {1'b0, acc} + {1'b0, dval};
  assign diff = {1'b0, acc} - {1'b0, dval};

  assign z_flag      = (acc == '0);
  assign unused_bits = ^inst[11:0];

  assign idle       = (state == S_IDLE) || (state == S_HALT);
  assign load_ready = idle && !start;
  assign load_fire  = load_valid && load_ready;
  assign exec_st    = (state == S_EXEC) && (op == OP_ST);

  assign busy   = (state == S_FETCH) || (state == S_EXEC);
  assign halted = (state == S_HALT);
  assign pc_dbg = pc;

  // RAMs keep their contents across reset
  always_ff @(posedge clk) begin
    if (load_fire && phase_lo)
      pram[ptr] <= {hi_byte, load_data};
    if (exec_st)
      dram[a] <= acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      acc       <= '0;
      c_flag    <= 1'b0;
      inst      <= '0;
      ptr       <= '0;
      phase_lo  <= 1'b0;
      hi_byte   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= '0;
            acc      <= '0;
            c_flag   <= 1'b0;
            ptr      <= '0;
            phase_lo <= 1'b0;
          end else if (load_fire) begin
            if (!phase_lo) begin
              hi_byte  <= load_data;
              phase_lo <= 1'b1;
            end else begin
              phase_lo <= 1'b0;
              ptr      <= ptr + P_ONE;
            end
          end
        end
        S_FETCH: begin
          inst  <= pram[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          pc    <= pc + P_ONE;
          case (op)
            OP_LDI: acc <= imm;
            OP_LD:  acc <= dval;
            OP_ADD: {c_flag, acc} <= sum;
            OP_SUB: begin
              acc    <= diff[DATA_W-1:0];
              c_flag <= diff[DATA_W];
            end
            OP_JMP: pc <= tgt;
            OP_JZ:  if (z_flag) pc <= tgt;
            OP_JC:  if (c_flag) pc <= tgt;
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_HALT: begin
              state <= S_HALT;
              pc    <= pc;
            end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n1_core.sv
// Directed bench for n1_core: load, run, branches, loops,
// reset abort, load/start contention and busy gating.
module tb_n1_core;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       start;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       halted;
  logic [3:0] pc_dbg;

  int n_tests;
  int n_fail;
  int out_vals[$];
  int out_edges[$];
  int halt_edge;

  n1_core #(.DATA_W(8), .PROG_AW(4), .DATA_AW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .start(start),
    .out_data(out_data),
    .out_valid(out_valid),
    .busy(busy),
    .halted(halted),
    .pc_dbg(pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qv(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic load_word(input logic [15:0] w);
    load_valid = 1'b1;
    load_data  = w[15:8];
    @(negedge clk);
    load_data  = w[7:0];
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Start at a negedge; edge 0 is the edge that samples start.
  task automatic run(input int bound, input bit hold_load,
                     input int kick_at);
    out_vals.delete();
    out_edges.delete();
    halt_edge = -1;
    start = 1'b1;
    if (hold_load) load_valid = 1'b1;
    #1;
    check("ready_at_start", load_ready, 0);
    @(negedge clk);
    for (int e = 1; e <= bound; e++) begin
      start = (e == kick_at);
      #1;
      if (hold_load) check("ready_busy", load_ready, 0);
      @(negedge clk);
      if (out_valid) begin
        out_vals.push_back(int'(out_data));
        out_edges.push_back(e);
      end
      if (halted) begin
        halt_edge = e;
        break;
      end
    end
    start      = 1'b0;
    load_valid = 1'b0;
    check("halt_reached", halted, 1);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    start      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc_dbg, 0);
    check("rst_out", out_data, 0);
    check("rst_outv", out_valid, 0);
    check("rst_ready", load_ready, 1);

    // T2: 3 + 4 -> OUT 7, halt
    load_word(16'h1003);
    load_word(16'h3000);
    load_word(16'h1004);
    load_word(16'h4000);
    load_word(16'h8000);
    load_word(16'hF000);
    run(100, 1'b0, -1);
    check("t2_nout", out_vals.size(), 1);
    check("t2_val", qv(out_vals, 0), 7);
    check("t2_edge", qv(out_edges, 0), 10);
    check("t2_halt", halt_edge, 12);
    check("t2_hold", out_data, 7);

    // T3: FF+01 carries, JC and JZ both taken
    load_word(16'h10FF);
    load_word(16'h3000);
    load_word(16'h1001);
    load_word(16'h4000);
    load_word(16'h9006);
    load_word(16'h8000);
    load_word(16'h7008);
    load_word(16'h8000);
    load_word(16'h8000);
    load_word(16'hF000);
    run(100, 1'b0, -1);
    check("t3_nout", out_vals.size(), 1);
    check("t3_val", qv(out_vals, 0), 0);
    check("t3_edge", qv(out_edges, 0), 14);
    check("t3_halt", halt_edge, 16);

    // T4: countdown 3 -> 0
    load_word(16'h1001);
    load_word(16'h3000);
    load_word(16'h1003);
    load_word(16'h5000);
    load_word(16'h8000);
    load_word(16'h7007);
    load_word(16'h6003);
    load_word(16'hF000);
    run(200, 1'b0, -1);
    check("t4_nout", out_vals.size(), 3);
    check("t4_v0", qv(out_vals, 0), 2);
    check("t4_v1", qv(out_vals, 1), 1);
    check("t4_v2", qv(out_vals, 2), 0);
    check("t4_halt", halt_edge, 30);

    // T6: load_valid held, start kicked while busy
    run(200, 1'b1, 7);
    check("t6_nout", out_vals.size(), 3);
    check("t6_v0", qv(out_vals, 0), 2);
    check("t6_v2", qv(out_vals, 2), 0);
    check("t6_halt", halt_edge, 30);

    // T1: reset in the middle of a run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("t1_pre_out", out_data, 2);
    check("t1_pre_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("t1_busy", busy, 0);
    check("t1_halted", halted, 0);
    check("t1_pc", pc_dbg, 0);
    check("t1_out", out_data, 0);
    check("t1_ready", load_ready, 1);

    // T5: HALT high byte, then low byte collides with start
    load_valid = 1'b1;
    load_data  = 8'hF0;
    @(negedge clk);
    load_data  = 8'h00;
    run(200, 1'b1, -1);
    check("t5_nout", out_vals.size(), 3);
    check("t5_v0", qv(out_vals, 0), 2);
    check("t5_halt", halt_edge, 30);

    // T5: 17 instrs wrap, pram[0] takes the last one
    load_word(16'hF000);
    load_word(16'h8000);
    for (int i = 2; i < 16; i++) load_word(16'hF000);
    load_word(16'h1009);
    run(100, 1'b0, -1);
    check("t5w_nout", out_vals.size(), 1);
    check("t5w_val", qv(out_vals, 0), 9);
    check("t5w_halt", halt_edge, 6);
    check("t5w_pc", pc_dbg, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
